// File: rtl/gamma_lut_pkg.sv
// Shared constants, types and the bank-address helper for the gamma LUT stage.
package gamma_lut_pkg;

   localparam logic [1:0] CH_R = 2'd0;
   localparam logic [1:0] CH_G = 2'd1;
   localparam logic [1:0] CH_B = 2'd2;

   localparam int unsigned GAMMA_LUT_LATENCY = 2;

   // Widest pixel the helper supports; callers cast the result down to their own width
   localparam int unsigned PW_MAX   = 16;
   localparam int unsigned ADDR_MAX = PW_MAX + 1;

   typedef enum logic {
      SW_IDLE = 1'b0,
      SW_PEND = 1'b1
   } swap_state_e;

   // Forms {bank, idx} for a table of 2^pw entries per bank
   function automatic logic [ADDR_MAX-1:0] bank_addr(input logic              bank,
                                                      input logic [PW_MAX-1:0] idx,
                                                      input int unsigned       pw);
      return ADDR_MAX'(idx) | (ADDR_MAX'(bank) << pw);
   endfunction

endpackage

// File: rtl/gamma_lut_if.sv
// Video and host-table bus of the gamma LUT stage.
// Readback signals exist only when GAMMA_LUT_READBACK_EN is defined.
interface gamma_lut_if #(
   parameter int unsigned PIXEL_WIDTH = 8
);
   logic                       bypass;
   logic [3*PIXEL_WIDTH-1:0]   di_i;
   logic                       de_i;
   logic                       hs_i;
   logic                       vs_i;
   logic [3*PIXEL_WIDTH-1:0]   do_o;
   logic                       de_o;
   logic                       hs_o;
   logic                       vs_o;
   logic                       lut_wr_i;
   logic [1:0]                 lut_ch_i;
   logic [PIXEL_WIDTH-1:0]     lut_addr_i;
   logic [PIXEL_WIDTH-1:0]     lut_wdata_i;
   logic                       lut_swap_i;
   logic                       lut_swap_pend_o;
   logic                       lut_swap_done_o;
   logic                       lut_bank_o;
`ifdef GAMMA_LUT_READBACK_EN
   logic                       lut_rd_i;
   logic [PIXEL_WIDTH-1:0]     lut_rdata_o;
   logic                       lut_rvld_o;
`endif

   modport master (
      output bypass, di_i, de_i, hs_i, vs_i,
      output lut_wr_i, lut_ch_i, lut_addr_i, lut_wdata_i, lut_swap_i,
`ifdef GAMMA_LUT_READBACK_EN
      output lut_rd_i,
      input  lut_rdata_o, lut_rvld_o,
`endif
      input  do_o, de_o, hs_o, vs_o,
      input  lut_swap_pend_o, lut_swap_done_o, lut_bank_o
   );

   modport slave (
      input  bypass, di_i, de_i, hs_i, vs_i,
      input  lut_wr_i, lut_ch_i, lut_addr_i, lut_wdata_i, lut_swap_i,
`ifdef GAMMA_LUT_READBACK_EN
      input  lut_rd_i,
      output lut_rdata_o, lut_rvld_o,
`endif
      output do_o, de_o, hs_o, vs_o,
      output lut_swap_pend_o, lut_swap_done_o, lut_bank_o
   );

endinterface

// File: rtl/gamma_lut_ram.sv
// One channel's two-bank table: port A host write (and read with GAMMA_LUT_READBACK_EN),
// port B synchronous video read. Contents are never reset.
module gamma_lut_ram #(
   parameter int unsigned PW = 8
) (
   input  logic          clk,
   input  logic          a_we,
   input  logic [PW:0]   a_addr,
   input  logic [PW-1:0] a_wdata,
`ifdef GAMMA_LUT_READBACK_EN
   input  logic          a_re,
   output logic [PW-1:0] a_rdata,
`endif
   input  logic [PW:0]   b_addr,
   output logic [PW-1:0] b_rdata
);
   localparam int unsigned DEPTH = 2 ** (PW + 1);

   logic [PW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (a_we) mem[a_addr] <= a_wdata;
      b_rdata <= mem[b_addr];
   end

`ifdef GAMMA_LUT_READBACK_EN
   always_ff @(posedge clk) begin
      if (a_re) a_rdata <= mem[a_addr];
   end
`endif

endmodule

// File: rtl/gamma_lut.sv
// Per-channel gamma LUT with double-buffered tables swapped at frame start, fixed 2-cycle latency.
// Optional host readback of the inactive bank: define GAMMA_LUT_READBACK_EN.
module gamma_lut
   import gamma_lut_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   gamma_lut_if.slave bus
);
   localparam int unsigned PW = PIXEL_WIDTH;
   localparam int unsigned AW = PW + 1;
   localparam int unsigned DW = 3 * PW;

   swap_state_e        state_q, state_d;
   logic               bank_q, bank_d;
   logic               done_q, done_d;
   logic               frame_start;

   logic               vs_q, hs_q, de_q, byp_q;
   logic [DW-1:0]      pix_q;
   logic               vs_out_q, hs_out_q, de_out_q;
   logic [DW-1:0]      do_q;
   logic [2:0][PW-1:0] vid_data;

   logic               ch_ok;
   logic               wr_en;
   logic [AW-1:0]      host_addr;

   assign frame_start = bus.vs_i & ~vs_q;
   assign ch_ok       = (bus.lut_ch_i != 2'd3);
   // Gating with rst_n drops a write that coincides with reset
   assign wr_en       = bus.lut_wr_i & ch_ok & rst_n;
   assign host_addr   = AW'(bank_addr(~bank_q, PW_MAX'(bus.lut_addr_i), PW));

   // Swap request control
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      done_d  = 1'b0;
      case (state_q)
         SW_IDLE: begin
            if (bus.lut_swap_i) begin
               if (frame_start) begin
                  bank_d = ~bank_q;
                  done_d = 1'b1;
               end else begin
                  state_d = SW_PEND;
               end
            end
         end
         SW_PEND: begin
            if (frame_start) begin
               bank_d  = ~bank_q;
               done_d  = 1'b1;
               state_d = SW_IDLE;
            end
         end
         default: state_d = SW_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SW_IDLE;
         bank_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         done_q  <= done_d;
      end
   end

   // Stage 0 captures pixel and controls while the RAMs read; stage 1 selects the output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q     <= 1'b0;
         hs_q     <= 1'b0;
         de_q     <= 1'b0;
         byp_q    <= 1'b0;
         pix_q    <= '0;
         vs_out_q <= 1'b0;
         hs_out_q <= 1'b0;
         de_out_q <= 1'b0;
         do_q     <= '0;
      end else begin
         vs_q     <= bus.vs_i;
         hs_q     <= bus.hs_i;
         de_q     <= bus.de_i;
         byp_q    <= bus.bypass;
         pix_q    <= bus.di_i;
         vs_out_q <= vs_q;
         hs_out_q <= hs_q;
         de_out_q <= de_q;
         do_q     <= byp_q ? pix_q : DW'(vid_data);
      end
   end

`ifdef GAMMA_LUT_READBACK_EN
   logic               rd_en;
   logic               rd_vld_q, rvld_q;
   logic [1:0]         rd_ch_q;
   logic [PW-1:0]      rdata_q, rd_mux;
   logic [2:0][PW-1:0] host_data;

   // A simultaneous write wins; the read is dropped
   assign rd_en = bus.lut_rd_i & ~bus.lut_wr_i & ch_ok;

   always_comb begin
      rd_mux = host_data[0];
      case (rd_ch_q)
         CH_G:    rd_mux = host_data[1];
         CH_B:    rd_mux = host_data[2];
         default: rd_mux = host_data[0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q <= 1'b0;
         rd_ch_q  <= CH_R;
         rvld_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rd_vld_q <= rd_en;
         rd_ch_q  <= bus.lut_ch_i;
         rvld_q   <= rd_vld_q;
         if (rd_vld_q) rdata_q <= rd_mux;
      end
   end

   assign bus.lut_rvld_o  = rvld_q;
   assign bus.lut_rdata_o = rdata_q;
`endif

   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic          we;
      logic [AW-1:0] vid_addr;

      assign we       = wr_en && (bus.lut_ch_i == 2'(c));
      assign vid_addr = AW'(bank_addr(bank_q, PW_MAX'(bus.di_i[PW*c +: PW]), PW));

      gamma_lut_ram #(
         .PW (PW)
      ) u_ram (
         .clk     (clk),
         .a_we    (we),
         .a_addr  (host_addr),
         .a_wdata (bus.lut_wdata_i),
`ifdef GAMMA_LUT_READBACK_EN
         .a_re    (rd_en && (bus.lut_ch_i == 2'(c))),
         .a_rdata (host_data[c]),
`endif
         .b_addr  (vid_addr),
         .b_rdata (vid_data[c])
      );
   end

   assign bus.do_o            = do_q;
   assign bus.de_o            = de_out_q;
   assign bus.hs_o            = hs_out_q;
   assign bus.vs_o            = vs_out_q;
   assign bus.lut_swap_pend_o = (state_q == SW_PEND);
   assign bus.lut_swap_done_o = done_q;
   assign bus.lut_bank_o      = bank_q;

endmodule

// File: tb/tb_gamma_lut.sv
// Directed bench for gamma_lut: table mapping, swap timing, bypass streaming, reset, readback.
module tb_gamma_lut;
   import gamma_lut_pkg::*;

   localparam int unsigned PW = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   gamma_lut_if #(.PIXEL_WIDTH(PW)) bus ();

   gamma_lut #(.PIXEL_WIDTH(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lut_write(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] d);
      bus.lut_wr_i    = 1'b1;
      bus.lut_ch_i    = ch;
      bus.lut_addr_i  = a;
      bus.lut_wdata_i = d;
      tick();
      bus.lut_wr_i    = 1'b0;
   endtask

   // Bank 1 tables: R identity, G inverted, B constant 0x40
   function automatic logic [23:0] bank1_map(input logic [23:0] p);
      logic [7:0] g;
      g = p[15:8];
      return {8'h40, 8'hFF - g, p[7:0]};
   endfunction

   logic [26:0] exp_hist [20];
   logic [31:0] r;
   logic [23:0] d;
   logic        by;

   initial begin
      bus.bypass      = 1'b0;
      bus.di_i        = '0;
      bus.de_i        = 1'b0;
      bus.hs_i        = 1'b0;
      bus.vs_i        = 1'b0;
      bus.lut_wr_i    = 1'b0;
      bus.lut_ch_i    = CH_R;
      bus.lut_addr_i  = '0;
      bus.lut_wdata_i = '0;
      bus.lut_swap_i  = 1'b0;
`ifdef GAMMA_LUT_READBACK_EN
      bus.lut_rd_i    = 1'b0;
`endif
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_do",   32'(bus.do_o), 32'h0);
      check("rst_de",   32'(bus.de_o), 32'h0);
      check("rst_hs",   32'(bus.hs_o), 32'h0);
      check("rst_vs",   32'(bus.vs_o), 32'h0);
      check("rst_pend", 32'(bus.lut_swap_pend_o), 32'h0);
      check("rst_done", 32'(bus.lut_swap_done_o), 32'h0);
      check("rst_bank", 32'(bus.lut_bank_o), 32'h0);
`ifdef GAMMA_LUT_READBACK_EN
      check("rst_rvld",  32'(bus.lut_rvld_o), 32'h0);
      check("rst_rdata", 32'(bus.lut_rdata_o), 32'h0);
`endif
      repeat (3) tick();
      #2 rst_n = 1'b1;
      tick();

      // Load inactive bank 1
      for (int i = 0; i < 256; i++) begin
         lut_write(CH_R, 8'(i), 8'(i));
         lut_write(CH_G, 8'(i), 8'(255 - i));
         lut_write(CH_B, 8'(i), 8'h40);
      end

      // Swap request five cycles ahead of the vs rise
      bus.lut_swap_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.lut_swap_i = 1'b0;
         check("pend_wait", 32'(bus.lut_swap_pend_o), 32'h1);
         check("bank_wait", 32'(bus.lut_bank_o), 32'h0);
      end
      bus.vs_i = 1'b1;
      tick();
      check("swap_done", 32'(bus.lut_swap_done_o), 32'h1);
      check("swap_pend", 32'(bus.lut_swap_pend_o), 32'h0);
      check("swap_bank", 32'(bus.lut_bank_o), 32'h1);
      bus.di_i = 24'hFF1010;
      bus.de_i = 1'b1;
      tick();
      check("done_once1", 32'(bus.lut_swap_done_o), 32'h0);
      tick();
      check("map_first", 32'(bus.do_o), 32'h0040EF10);
      check("map_de",    32'(bus.de_o), 32'h1);
      check("done_once2", 32'(bus.lut_swap_done_o), 32'h0);

      // Second frame start without a request
      bus.vs_i = 1'b0;
      repeat (2) tick();
      bus.vs_i = 1'b1;
      tick();
      check("noreq_bank", 32'(bus.lut_bank_o), 32'h1);
      check("noreq_done", 32'(bus.lut_swap_done_o), 32'h0);

      // More table vectors
      bus.di_i = 24'h12FF00;
      tick();
      bus.di_i = 24'h0001AB;
      tick();
      check("map_v1", 32'(bus.do_o), 32'h00400000);
      tick();
      check("map_v2", 32'(bus.do_o), 32'h0040FEAB);

      // Bypass-only then mixed streaming against the table model
      for (int i = 0; i < 20; i++) begin
         r  = $urandom;
         by = (i < 10) ? 1'b1 : r[31];
         d  = 24'($urandom);
         bus.bypass = by;
         bus.de_i   = r[30];
         bus.hs_i   = r[29];
         bus.vs_i   = r[28];
         bus.di_i   = d;
         exp_hist[i] = {r[28], r[29], r[30], by ? d : bank1_map(d)};
         tick();
         if (i > 0) check("stream", 32'({bus.vs_o, bus.hs_o, bus.de_o, bus.do_o}), 32'(exp_hist[i-1]));
      end

      // Mid-frame write into the inactive bank
      bus.bypass = 1'b0;
      bus.de_i   = 1'b1;
      bus.hs_i   = 1'b0;
      bus.vs_i   = 1'b1;
      bus.di_i   = 24'h808080;
      repeat (2) tick();
      check("mid_old", 32'(bus.do_o), 32'h00407F80);
      lut_write(CH_R, 8'h80, 8'h00);
      lut_write(CH_G, 8'h80, 8'h11);
      lut_write(CH_B, 8'h80, 8'h22);
      check("mid_hold", 32'(bus.do_o), 32'h00407F80);
      bus.lut_swap_i = 1'b1;
      tick();
      bus.lut_swap_i = 1'b0;
      check("mid_pend", 32'(bus.lut_swap_pend_o), 32'h1);
      bus.vs_i = 1'b0;
      tick();
      check("mid_pre", 32'(bus.do_o), 32'h00407F80);
      bus.vs_i = 1'b1;
      tick();
      check("mid_bank", 32'(bus.lut_bank_o), 32'h0);
      check("mid_done", 32'(bus.lut_swap_done_o), 32'h1);
      tick();
      check("mid_edge", 32'(bus.do_o), 32'h00407F80);
      tick();
      check("mid_new", 32'(bus.do_o), 32'h00221100);

      // Reset mid-frame with bank 1 active and a swap pending
      bus.lut_swap_i = 1'b1;
      tick();
      bus.lut_swap_i = 1'b0;
      bus.vs_i = 1'b0;
      tick();
      bus.vs_i = 1'b1;
      tick();
      check("pre_rst_bank", 32'(bus.lut_bank_o), 32'h1);
      bus.lut_swap_i = 1'b1;
      tick();
      bus.lut_swap_i = 1'b0;
      check("pre_rst_pend", 32'(bus.lut_swap_pend_o), 32'h1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_do",   32'(bus.do_o), 32'h0);
      check("arst_de",   32'(bus.de_o), 32'h0);
      check("arst_vs",   32'(bus.vs_o), 32'h0);
      check("arst_pend", 32'(bus.lut_swap_pend_o), 32'h0);
      check("arst_bank", 32'(bus.lut_bank_o), 32'h0);
      tick();
      #2 rst_n = 1'b1;
      bus.bypass = 1'b1;
      bus.di_i   = 24'hA5C3E7;
      bus.de_i   = 1'b1;
      bus.hs_i   = 1'b1;
      bus.vs_i   = 1'b0;
      tick();
      check("post_lat1_de", 32'(bus.de_o), 32'h0);
      check("post_lat1_hs", 32'(bus.hs_o), 32'h0);
      tick();
      check("post_lat2_do", 32'(bus.do_o), 32'h00A5C3E7);
      check("post_lat2_de", 32'(bus.de_o), 32'h1);
      check("post_lat2_hs", 32'(bus.hs_o), 32'h1);

`ifdef GAMMA_LUT_READBACK_EN
      lut_write(CH_G, 8'h33, 8'h5A);
      bus.lut_rd_i   = 1'b1;
      bus.lut_ch_i   = CH_G;
      bus.lut_addr_i = 8'h33;
      tick();
      bus.lut_rd_i = 1'b0;
      check("rb_lat1", 32'(bus.lut_rvld_o), 32'h0);
      tick();
      check("rb_vld",  32'(bus.lut_rvld_o), 32'h1);
      check("rb_data", 32'(bus.lut_rdata_o), 32'h5A);
      tick();
      check("rb_end",  32'(bus.lut_rvld_o), 32'h0);
      bus.lut_rd_i    = 1'b1;
      bus.lut_wr_i    = 1'b1;
      bus.lut_ch_i    = CH_G;
      bus.lut_addr_i  = 8'h34;
      bus.lut_wdata_i = 8'h77;
      tick();
      bus.lut_rd_i = 1'b0;
      bus.lut_wr_i = 1'b0;
      check("rbwr_1", 32'(bus.lut_rvld_o), 32'h0);
      tick();
      check("rbwr_2", 32'(bus.lut_rvld_o), 32'h0);
      bus.lut_rd_i = 1'b1;
      tick();
      bus.lut_rd_i = 1'b0;
      tick();
      check("rbwr_vld",  32'(bus.lut_rvld_o), 32'h1);
      check("rbwr_data", 32'(bus.lut_rdata_o), 32'h77);
`endif

      check("latency_const", 32'(GAMMA_LUT_LATENCY), 32'(2));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
